// File: rtl/dvsd_rr_arbiter.sv
// Round-robin arbiter: grants one of N level-sensitive requesters, search starts at a rotating pointer.
// Latency: 1 clk edge from sampled req to registered gnt; one forced idle cycle after every grant.
// Backpressure: en=0 blocks new grants only; a grant is held until released or MAX_HOLD cycles expire.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   en              arbitration enable (ignored while a grant is held)
//   req[N]          request vector, bit i = requester i
//   gnt[N]          registered one-hot grant, zero when idle
//   gnt_id[IDW]     registered index of the granted requester (holds last value when idle)
//   gnt_valid       registered, high while a grant is held
//   timeout         registered one-cycle pulse on forced revoke
//   gs, eno         combinational: any request pending / enabled with nothing pending
module dvsd_rr_arbiter #(
    parameter int N        = 8,
    parameter int IDW      = 3,
    parameter int MAX_HOLD = 16,
    parameter int CW       = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           timeout,
    output logic           gs,
    output logic           eno
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [IDW-1:0] r_ptr;
    logic [CW-1:0]  r_hold_cnt;
    logic [N-1:0]   r_gnt;
    logic [IDW-1:0] r_gnt_id;
    logic           r_gnt_valid;
    logic           r_timeout;

    logic [IDW-1:0] w_ptr_nxt;
    logic [CW-1:0]  w_hold_nxt;
    logic [N-1:0]   w_gnt_nxt;
    logic [IDW-1:0] w_gnt_id_nxt;
    logic           w_gnt_valid_nxt;
    logic           w_timeout_nxt;

    logic           w_req_any;
    logic           w_release;
    logic           w_revoke;
    logic           w_start;
    logic [IDW-1:0] w_win_id;

    assign w_req_any = |req;
    assign w_start   = en & w_req_any;
    // Release takes precedence: a revoke is only possible while the owner still requests.
    assign w_release = ~req[r_gnt_id];
    assign w_revoke  = req[r_gnt_id] & (r_hold_cnt == CW'(MAX_HOLD - 1));

    // Rotating priority search: first set req bit at ptr, ptr+1, ... wrapping mod N.
    // IDW = log2(N), so the index addition wraps naturally.
    always_comb begin
        logic           v_found;
        logic [IDW-1:0] v_idx;
        v_found  = 1'b0;
        v_idx    = '0;
        w_win_id = '0;
        for (int k = 0; k < N; k++) begin
            v_idx = r_ptr + IDW'(k);
            if (!v_found && req[v_idx]) begin
                v_found  = 1'b1;
                w_win_id = v_idx;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_hold_cnt  <= '0;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start)              w_state_nxt = S_BUSY;
            S_BUSY:  if (w_release || w_revoke) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer and hold counter.
    always_comb begin
        w_ptr_nxt       = r_ptr;
        w_hold_nxt      = r_hold_cnt;
        w_gnt_nxt       = r_gnt;
        w_gnt_id_nxt    = r_gnt_id;
        w_gnt_valid_nxt = r_gnt_valid;
        w_timeout_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Leaving BUSY always passes through here, which enforces the one-cycle grant gap.
                w_gnt_nxt       = '0;
                w_gnt_valid_nxt = 1'b0;
                if (w_start) begin
                    w_gnt_nxt       = N'(1) << w_win_id;
                    w_gnt_id_nxt    = w_win_id;
                    w_gnt_valid_nxt = 1'b1;
                    w_hold_nxt      = '0;
                end
            end
            S_BUSY: begin
                if (w_release || w_revoke) begin
                    w_gnt_nxt       = '0;
                    w_gnt_valid_nxt = 1'b0;
                    w_ptr_nxt       = r_gnt_id + IDW'(1);
                    w_timeout_nxt   = w_revoke;
                end else begin
                    w_hold_nxt = r_hold_cnt + CW'(1);
                end
            end
            default: begin
                w_gnt_nxt       = '0;
                w_gnt_valid_nxt = 1'b0;
            end
        endcase
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;
    assign gs        = w_req_any;
    assign eno       = en & ~w_req_any;

endmodule

// File: tb/tb_dvsd_rr_arbiter.sv
// Self-checking bench for dvsd_rr_arbiter: directed scenarios then randomized traffic,
// all outputs compared every cycle against a cycle-count reference model.
// Inputs driven between edges, outputs sampled 1 time unit after the rising edge.
module tb_dvsd_rr_arbiter;

    localparam int N        = 8;
    localparam int IDW      = 3;
    localparam int MAX_HOLD = 16;
    localparam int CW       = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic           en;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_valid;
    logic           timeout;
    logic           gs;
    logic           eno;

    dvsd_rr_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout),
        .gs        (gs),
        .eno       (eno)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the resource, how many cycles it has held it,
    // where the next search starts, last granted id, and the revoke pulse.
    int m_owner;
    int m_held;
    int m_ptr;
    int m_last;
    bit m_to;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
        m_last  = 0;
        m_to    = 1'b0;
    endtask

    // Applies one rising edge to the model using the currently driven inputs.
    task automatic model_step();
        m_to = 1'b0;
        if (m_owner < 0) begin
            if (en && req != '0) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr + k) % N;
                    if (m_owner < 0 && req[i]) begin
                        m_owner = i;
                        m_last  = i;
                        m_held  = 1;
                    end
                end
            end
        end else if (!req[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else if (m_held >= MAX_HOLD) begin
            m_to    = 1'b1;
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else begin
            m_held++;
        end
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] exp_gnt;
        exp_gnt = '0;
        if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
        check({tag, ".gnt"},       32'(gnt),       32'(exp_gnt));
        check({tag, ".gnt_id"},    32'(gnt_id),    32'(m_last));
        check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(m_owner >= 0));
        check({tag, ".timeout"},   32'(timeout),   32'(m_to));
        check({tag, ".gs"},        32'(gs),        32'(req != '0));
        check({tag, ".eno"},       32'(eno),       32'(en && req == '0));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed between edges; called right after a tick.
    task automatic mid_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #2 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        en    = 1'b1;
        req   = 8'hFF;
        model_reset();

        // 1: reset with all requests pending
        #2 reset = 1'b1;
        #1;
        check("t1.gnt", 32'(gnt), 32'h0);
        check("t1.gnt_valid", 32'(gnt_valid), 32'h0);
        check("t1.timeout", 32'(timeout), 32'h0);
        check("t1.gnt_id", 32'(gnt_id), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t1.gs", 32'(gs), 32'h1);
        check("t1.eno", 32'(eno), 32'h0);
        req = 8'h00;
        #1;
        check("t1.eno_idle", 32'(eno), 32'h1);
        tick("t1.idle");

        // 2: single request, release, pointer moves to 4
        req = 8'h08; tick("t2.grant");
        check("t2.gnt", 32'(gnt), 32'h08);
        check("t2.gnt_id", 32'(gnt_id), 32'h3);
        req = 8'h00; tick("t2.release");
        check("t2.gnt_rel", 32'(gnt), 32'h0);
        check("t2.gnt_id_held", 32'(gnt_id), 32'h3);
        req = 8'h11; tick("t2.ptr4");
        check("t2.ptr4_gnt", 32'(gnt), 32'h10);
        req = 8'h00; tick("t2.rel4");
        // move pointer to 0 via requester 7
        req = 8'h80; tick("t2.g7");
        req = 8'h00; tick("t2.r7");

        // 3: ptr=0, both ends request
        req = 8'h81; tick("t3.g0");
        check("t3.g0_gnt", 32'(gnt), 32'h01);
        req = 8'h80; tick("t3.gap");
        check("t3.gap_gnt", 32'(gnt), 32'h0);
        tick("t3.g7");
        check("t3.g7_gnt", 32'(gnt), 32'h80);
        check("t3.g7_id", 32'(gnt_id), 32'h7);
        req = 8'h00; tick("t3.r7");
        req = 8'h81; tick("t3.wrap");
        check("t3.wrap_gnt", 32'(gnt), 32'h01);
        req = 8'h00; tick("t3.r0");

        // 4: hold timeout on requester 5, then 0 wins after ptr wraps from 6
        req = 8'h20; tick("t4.g5");
        for (int c = 1; c < MAX_HOLD; c++) tick("t4.hold");
        check("t4.held_gnt", 32'(gnt), 32'h20);
        tick("t4.revoke");
        check("t4.revoke_gnt", 32'(gnt), 32'h0);
        check("t4.revoke_to", 32'(timeout), 32'h1);
        req = 8'h21; tick("t4.next");
        check("t4.next_gnt", 32'(gnt), 32'h01);
        check("t4.next_to", 32'(timeout), 32'h0);
        // release on the would-be revoke edge: no timeout pulse
        for (int c = 1; c < MAX_HOLD; c++) tick("t4.hold2");
        req = 8'h20; tick("t4.relwins");
        check("t4.relwins_to", 32'(timeout), 32'h0);
        req = 8'h00; tick("t4.idle");

        // 5: enable gating
        en = 1'b0; req = 8'h10;
        #1;
        check("t5.gs", 32'(gs), 32'h1);
        check("t5.eno", 32'(eno), 32'h0);
        tick("t5.blocked");
        check("t5.blocked_gnt", 32'(gnt), 32'h0);
        en = 1'b1; tick("t5.g4");
        check("t5.g4_gnt", 32'(gnt), 32'h10);
        en = 1'b0; tick("t5.kept");
        check("t5.kept_gnt", 32'(gnt), 32'h10);
        req = 8'h00; tick("t5.rel");
        en = 1'b1;

        // 6: async reset mid-grant
        req = 8'h04; tick("t6.g2");
        check("t6.g2_gnt", 32'(gnt), 32'h04);
        mid_reset("t6.rst");
        check("t6.rst_gnt", 32'(gnt), 32'h0);
        check("t6.rst_to", 32'(timeout), 32'h0);
        req = 8'h00; tick("t6.rel");
        req = 8'h05; tick("t6.g0");
        check("t6.g0_gnt", 32'(gnt), 32'h01);
        req = 8'h00; tick("t6.idle");

        // Randomized traffic: sticky requests so grants last long enough to hit timeouts.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 19) == 0) req[b] = ~req[b];
            en = ($urandom_range(0, 7) != 0);
            tick("rnd");
            if ($urandom_range(0, 499) == 0) mid_reset("rnd.rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
